grid_board_ctrl: RTL and testbench

- Owns the 8x8 board state behind the on-screen block grid: 64 cells, each CELL_W bits.
- Serves the pixel path: takes the 1..64 block index from the grid decoder and returns the cell value one cycle later.
- Shares the single write port between two requesters with round-robin arbitration; cursor/input logic is requester 0, game logic is requester 1.
- Sequences a full-board clear on command.

---
 rtl/grid_board_ctrl_pkg.sv | 35 +++
 rtl/grid_board_ctrl_arb.sv | 54 +++++
 rtl/grid_board_ctrl.sv | 124 ++++++++++++
 tb/tb_grid_board_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/grid_board_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// grid_board_ctrl_pkg
// Shared constants and types for the on-screen 8x8 block grid.
// The geometry constants are common to the grid decoder, the renderer and
// the board controller, so they live in one place.
// ---------------------------------------------------------------------------
package grid_board_ctrl_pkg;

    localparam int GRID_CELLS = 64;
    localparam int GRID_COLS  = 8;
    localparam int CELL_PX    = 10;
    localparam int GRID_X0    = 200;
    localparam int GRID_Y0    = 200;

    // The highest decoder index that still lands on a cell.
    localparam logic [7:0] GRID_LAST_BLOCK = 8'd64;

    // The last cell index that a clear sweep writes.
    localparam logic [5:0] GRID_LAST_IDX = 6'd63;

    // Meaning of a 2-bit cell value.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        P1     = 2'd1,
        P2     = 2'd2,
        CURSOR = 2'd3
    } cell_t;

    // Board controller sequencing states.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/grid_board_ctrl_arb.sv
// ---------------------------------------------------------------------------
// grid_rr_arb2
// Two-way round-robin arbiter with enable. The grant decision is
// combinational, and the index of the last winner is remembered so that a
// tie goes to the other requester. Immediately after reset requester 0 wins
// the first tie.
//
// Ports:
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_en            arbitration allowed this cycle
//   i_req0, i_req1  request lines
//   o_gnt_idx       index of the winning requester (valid with o_gnt_vld)
//   o_gnt_vld       a grant is being issued this cycle
// ---------------------------------------------------------------------------
module grid_rr_arb2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt_idx,
    output logic o_gnt_vld
);

    logic r_rr_last;

    // Pick a winner. On a tie, the requester that did not win last time wins.
    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_idx = 1'b0;
        if (i_en) begin
            if (i_req0 && i_req1) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = ~r_rr_last;
            end else if (i_req0) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = 1'b0;
            end else if (i_req1) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = 1'b1;
            end
        end
    end

    // Reset to 1 so that requester 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_last <= 1'b1;
        end else if (o_gnt_vld) begin
            r_rr_last <= o_gnt_idx;
        end
    end

endmodule

// File: rtl/grid_board_ctrl.sv
// ---------------------------------------------------------------------------
// grid_board_ctrl
// Holds the 8x8 board state that the block grid renders. It serves the pixel
// path with a read latency of one cycle. It shares the single write port
// between two requesters, and it sequences a full-board clear.
//
// Ports:
//   i_clk, i_rst_n            pixel clock, asynchronous active-low reset
//   i_block                   decoder index; 1..64 selects a cell, others are outside
//   o_pix_cell                registered cell value for the current pixel
//   i_clr_start / o_clr_busy  clear request pulse / a clear is in progress
//   i_reqN, i_addrN, i_dataN  write request N, held until it is granted
//   o_gntN                    one-cycle pulse on the edge where write N commits
// ---------------------------------------------------------------------------
module grid_board_ctrl
    import grid_board_ctrl_pkg::*;
#(
    parameter int                CELL_W  = 2,
    parameter logic [CELL_W-1:0] CLR_VAL = '0,
    parameter bit                SAFE_WR = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_block,
    output logic [CELL_W-1:0] o_pix_cell,
    input  logic              i_clr_start,
    output logic              o_clr_busy,
    input  logic              i_req0,
    input  logic [5:0]        i_addr0,
    input  logic [CELL_W-1:0] i_data0,
    output logic              o_gnt0,
    input  logic              i_req1,
    input  logic [5:0]        i_addr1,
    input  logic [CELL_W-1:0] i_data1,
    output logic              o_gnt1
);

    logic [CELL_W-1:0] r_mem [GRID_CELLS];
    logic [CELL_W-1:0] r_pix;
    logic              r_gnt0;
    logic              r_gnt1;
    logic [5:0]        r_clr_idx;
    state_t            r_state;
    state_t            w_next_state;

    logic              w_in_grid;
    logic [5:0]        w_rd_addr;
    logic              w_wr_ok;
    logic              w_arb_en;
    logic              w_gnt_idx;
    logic              w_gnt_vld;

    // Block 64 wraps to address 63 within the 6-bit subtraction.
    assign w_in_grid = (i_block != 8'd0) && (i_block <= GRID_LAST_BLOCK);
    assign w_rd_addr = i_block[5:0] - 6'd1;

    // With SAFE_WR set, writes wait until the beam is outside the grid.
    // A clear start wins over a grant in the same cycle.
    assign w_wr_ok  = !SAFE_WR || !w_in_grid;
    assign w_arb_en = w_wr_ok && (r_state == IDLE) && !i_clr_start;

    grid_rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (w_arb_en),
        .i_req0    (i_req0),
        .i_req1    (i_req1),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    // IDLE waits for a clear command. CLEAR sweeps all 64 cells once,
    // then returns to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_clr_start) w_next_state = CLEAR;
            CLEAR:   if (r_clr_idx == GRID_LAST_IDX) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Storage, pixel read, grant pulses and the clear sweep.
    // The read samples the old cell contents, so a write on the same edge
    // shows up on the following read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < GRID_CELLS; i++) begin
                r_mem[i] <= '0;
            end
            r_pix     <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_clr_idx <= '0;
            r_state   <= IDLE;
        end else begin
            r_state <= w_next_state;
            r_pix   <= w_in_grid ? r_mem[w_rd_addr] : '0;
            r_gnt0  <= w_gnt_vld && !w_gnt_idx;
            r_gnt1  <= w_gnt_vld && w_gnt_idx;
            if (r_state == CLEAR) begin
                r_mem[r_clr_idx] <= CLR_VAL;
                r_clr_idx        <= (r_clr_idx == GRID_LAST_IDX) ? 6'd0 : r_clr_idx + 6'd1;
            end else begin
                if (i_clr_start) begin
                    r_clr_idx <= '0;
                end
                if (w_gnt_vld) begin
                    if (w_gnt_idx) begin
                        r_mem[i_addr1] <= i_data1;
                    end else begin
                        r_mem[i_addr0] <= i_data0;
                    end
                end
            end
        end
    end

    assign o_pix_cell = r_pix;
    assign o_gnt0     = r_gnt0;
    assign o_gnt1     = r_gnt1;
    assign o_clr_busy = (r_state == CLEAR);

endmodule

// File: tb/tb_grid_board_ctrl.sv
// ---------------------------------------------------------------------------
// tb_grid_board_ctrl
// Directed testbench for grid_board_ctrl with the default parameters
// (CELL_W=2, CLR_VAL=0, SAFE_WR=1). Inputs change 1 ns after a rising edge,
// and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_grid_board_ctrl;

    logic       clk;
    logic       rstN;
    logic [7:0] block;
    logic [1:0] pixCell;
    logic       clrStart;
    logic       clrBusy;
    logic       req0, req1;
    logic [5:0] addr0, addr1;
    logic [1:0] data0, data1;
    logic       gnt0, gnt1;

    int checks = 0;
    int errors = 0;
    int busyCount;

    grid_board_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_block     (block),
        .o_pix_cell  (pixCell),
        .i_clr_start (clrStart),
        .o_clr_busy  (clrBusy),
        .i_req0      (req0),
        .i_addr0     (addr0),
        .i_data0     (data0),
        .o_gnt0      (gnt0),
        .i_req1      (req1),
        .i_addr1     (addr1),
        .i_data1     (data1),
        .o_gnt1      (gnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the given number of rising edges, then settle 1 ns past the last one.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present block b for one edge and check the value read one cycle later.
    task automatic readCell(input string tag, input logic [7:0] b, input logic [1:0] exp);
        block = b;
        applyStimulus(1);
        checkOutput(tag, {30'd0, pixCell}, {30'd0, exp});
    endtask

    initial begin
        rstN = 1'b0; block = 8'd0; clrStart = 1'b0;
        req0 = 1'b0; addr0 = '0; data0 = '0;
        req1 = 1'b0; addr1 = '0; data1 = '0;
        #12;
        checkOutput("rst_pix",  {30'd0, pixCell}, 32'd0);
        checkOutput("rst_busy", {31'd0, clrBusy}, 32'd0);
        checkOutput("rst_gnt",  {30'd0, gnt1, gnt0}, 32'd0);
        rstN = 1'b1;
        applyStimulus(1);

        $display("[TB] sweep of all cells after reset");
        for (int i = 1; i <= 64; i++) begin
            readCell($sformatf("sweep_%0d", i), 8'(i), 2'd0);
        end
        readCell("outside_0",  8'd0,  2'd0);
        readCell("outside_70", 8'd70, 2'd0);

        $display("[TB] single write from requester 0");
        block = 8'd0; req0 = 1'b1; addr0 = 6'd5; data0 = 2'd2;
        applyStimulus(1);
        checkOutput("w5_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        applyStimulus(1);
        checkOutput("w5_gnt_drop", {30'd0, gnt1, gnt0}, 32'd0);
        block = 8'd6;
        #1;
        checkOutput("w5_latency_prev", {30'd0, pixCell}, 32'd0);
        readCell("w5_read", 8'd6, 2'd2);
        readCell("w5_neighbour", 8'd7, 2'd0);

        $display("[TB] write while block 65 is outside the grid");
        block = 8'd65; req0 = 1'b1; addr0 = 6'd20; data0 = 2'd3;
        applyStimulus(1);
        checkOutput("b65_gnt", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        readCell("b65_read", 8'd21, 2'd3);

        $display("[TB] requester 1 stalled while beam is inside the grid");
        block = 8'd10; req1 = 1'b1; addr1 = 6'd9; data1 = 2'd1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("safe_stall", {30'd0, gnt1, gnt0}, 32'd0);
        end
        block = 8'd64;
        applyStimulus(1);
        checkOutput("safe_stall_b64", {30'd0, gnt1, gnt0}, 32'd0);
        block = 8'd0;
        applyStimulus(1);
        checkOutput("safe_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        req1 = 1'b0;
        readCell("safe_read", 8'd10, 2'd1);

        $display("[TB] both requesters held for four cycles");
        block = 8'd0;
        req0 = 1'b1; addr0 = 6'd1; data0 = 2'd1;
        req1 = 1'b1; addr1 = 6'd2; data1 = 2'd2;
        applyStimulus(1);
        checkOutput("rr_1", {30'd0, gnt1, gnt0}, 32'd1);
        applyStimulus(1);
        checkOutput("rr_2", {30'd0, gnt1, gnt0}, 32'd2);
        applyStimulus(1);
        checkOutput("rr_3", {30'd0, gnt1, gnt0}, 32'd1);
        applyStimulus(1);
        checkOutput("rr_4", {30'd0, gnt1, gnt0}, 32'd2);
        req0 = 1'b0; req1 = 1'b0;
        readCell("rr_cell1", 8'd2, 2'd1);
        readCell("rr_cell2", 8'd3, 2'd2);

        $display("[TB] preload corners, then clear with a pending request");
        block = 8'd0; req0 = 1'b1; addr0 = 6'd0; data0 = 2'd3;
        applyStimulus(1);
        req0 = 1'b0; req1 = 1'b1; addr1 = 6'd63; data1 = 2'd3;
        applyStimulus(1);
        req1 = 1'b0;
        readCell("pre_cell0",  8'd1,  2'd3);
        readCell("pre_cell63", 8'd64, 2'd3);
        block = 8'd0; clrStart = 1'b1;
        req0 = 1'b1; addr0 = 6'd30; data0 = 2'd1;
        applyStimulus(1);
        clrStart = 1'b0;
        checkOutput("clr_start", {30'd0, gnt0, clrBusy}, 32'd1);
        for (int i = 1; i < 64; i++) begin
            clrStart = (i == 30);
            applyStimulus(1);
            checkOutput($sformatf("clr_cyc_%0d", i), {30'd0, gnt0, clrBusy}, 32'd1);
        end
        clrStart = 1'b0;
        applyStimulus(1);
        checkOutput("clr_done", {30'd0, gnt0, clrBusy}, 32'd0);
        applyStimulus(1);
        checkOutput("clr_gnt_after", {30'd0, gnt0, clrBusy}, 32'd2);
        req0 = 1'b0;
        readCell("clr_cell0",  8'd1,  2'd0);
        readCell("clr_cell63", 8'd64, 2'd0);
        readCell("clr_cell30", 8'd31, 2'd1);

        $display("[TB] reset in the middle of a clear");
        block = 8'd0; req1 = 1'b1; addr1 = 6'd50; data1 = 2'd2;
        applyStimulus(1);
        req1 = 1'b0;
        readCell("mid_pre50", 8'd51, 2'd2);
        block = 8'd0; clrStart = 1'b1;
        applyStimulus(1);
        clrStart = 1'b0;
        applyStimulus(20);
        checkOutput("mid_busy_before", {31'd0, clrBusy}, 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_busy", {31'd0, clrBusy}, 32'd0);
        checkOutput("mid_rst_pix_gnt", {28'd0, pixCell, gnt1, gnt0}, 32'd0);
        #3;
        rstN = 1'b1;
        readCell("mid_cell50", 8'd51, 2'd0);
        block = 8'd0; clrStart = 1'b1;
        applyStimulus(1);
        clrStart = 1'b0;
        busyCount = 0;
        while (clrBusy && busyCount < 100) begin
            busyCount++;
            applyStimulus(1);
        end
        checkOutput("mid_full_clear_len", busyCount, 32'd64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
